// File: rtl/cache_mem_responder.sv
// cache_mem_responder
//   RAM-side responder for the cache manager's miss / write-back port.
//   Each request moves one word between the cache and a backing word memory:
//   loads land in one lane of the assembled block_from_ram, write-backs send
//   one lane of dc_data_wb to memory. Every completed word is acknowledged
//   with a one-cycle ram_ready pulse, unless the cache dropped its request
//   while the memory access was in flight.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   ram_en_in       cache requests a word transfer
//   ram_write_in    1 = write-back word, 0 = load word
//   ram_addr_in     word address, low OFFSET_WIDTH bits select the lane
//   dc_data_wb      write-back block from the D-cache
//   ram_ready       one-cycle completion pulse to the cache
//   block_from_ram  assembled load block (registered)
//   mem_req/mem_we/mem_addr/mem_wdata  backing-memory request (held until ack)
//   mem_rdata/mem_ack                  backing-memory response (single cycle)
//   busy            debug: responder not idle
module cache_mem_responder #(
  parameter int OFFSET_WIDTH = 3,
  parameter int ADDR_WIDTH   = 30,
  parameter int DATA_WIDTH   = 32,
  parameter int BLOCK_SIZE   = 1 << OFFSET_WIDTH,
  parameter int BLOCK_WIDTH  = DATA_WIDTH * BLOCK_SIZE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ram_en_in,
  input  logic                   ram_write_in,
  input  logic [ADDR_WIDTH-1:0]  ram_addr_in,
  input  logic [BLOCK_WIDTH-1:0] dc_data_wb,
  output logic                   ram_ready,
  output logic [BLOCK_WIDTH-1:0] block_from_ram,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_wdata,
  input  logic [DATA_WIDTH-1:0]  mem_rdata,
  input  logic                   mem_ack,
  output logic                   busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_stale;
  logic                   r_mem_req;
  logic                   r_mem_we;
  logic [ADDR_WIDTH-1:0]  r_mem_addr;
  logic [DATA_WIDTH-1:0]  r_mem_wdata;
  logic [BLOCK_WIDTH-1:0] r_block;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: one or more MEM cycles until ack, then a single RESP cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (ram_en_in) w_state_nxt = S_MEM;
        else           w_state_nxt = S_IDLE;
      end
      S_MEM: begin
        if (mem_ack) w_state_nxt = S_RESP;
        else         w_state_nxt = S_MEM;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request latch, memory handshake, stale tracking and load-lane update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stale     <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_block     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ram_en_in) begin
            // The latched copy is authoritative: the cache may move its
            // address while the memory access is pending.
            r_mem_addr  <= ram_addr_in;
            r_mem_we    <= ram_write_in;
            r_mem_wdata <= dc_data_wb[ram_addr_in[OFFSET_WIDTH-1:0]*DATA_WIDTH +: DATA_WIDTH];
            r_mem_req   <= 1'b1;
            r_stale     <= 1'b0;
          end
        end
        S_MEM: begin
          // A request withdrawn at any point of the access must not be acked.
          if (!ram_en_in) r_stale <= 1'b1;
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            if (!r_mem_we) begin
              r_block[r_mem_addr[OFFSET_WIDTH-1:0]*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
            end
          end
        end
        S_RESP: begin
          r_mem_req <= 1'b0;
        end
        default: begin
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  // The pulse is qualified by the live request so a dropped request never
  // advances the cache's block counter.
  assign ram_ready      = (r_state == S_RESP) && !r_stale && ram_en_in;
  assign block_from_ram = r_block;
  assign mem_req        = r_mem_req;
  assign mem_we         = r_mem_we;
  assign mem_addr       = r_mem_addr;
  assign mem_wdata      = r_mem_wdata;
  assign busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_cache_mem_responder.sv
// Self-checking bench for cache_mem_responder: directed scenarios followed by
// randomized requests. A reference model (word memory + block image) produces
// expected results; a memory responder checks the request side and a monitor
// checks block_from_ram on each ram_ready pulse.
module tb_cache_mem_responder;
  localparam int OW = 3;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int BS = 1 << OW;
  localparam int BW = DW * BS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ram_en_in = 1'b0;
  logic          ram_write_in = 1'b0;
  logic [AW-1:0] ram_addr_in = '0;
  logic [BW-1:0] dc_data_wb = '0;
  logic          ram_ready;
  logic [BW-1:0] block_from_ram;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          busy;

  cache_mem_responder dut (
    .clk(clk), .rst(rst), .ram_en_in(ram_en_in), .ram_write_in(ram_write_in),
    .ram_addr_in(ram_addr_in), .dc_data_wb(dc_data_wb), .ram_ready(ram_ready),
    .block_from_ram(block_from_ram), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } mreq_t;

  mreq_t         mq[$];      // expected backing-memory transactions
  logic [BW-1:0] rq[$];      // expected block image at each ram_ready
  logic [DW-1:0] ref_block [BS];
  logic [DW-1:0] mem_model [logic [AW-1:0]];
  int            ack_delay = 0;
  int            n_checks = 0;
  int            n_pass = 0;
  time           t_ready = 0;

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a[15:0], 16'h5A3C};
  endfunction

  function automatic logic [BW-1:0] ref_pack();
    logic [BW-1:0] b;
    for (int i = 0; i < BS; i++) b[i*DW +: DW] = ref_block[i];
    return b;
  endfunction

  function automatic logic [BW-1:0] rand_block();
    logic [BW-1:0] b;
    for (int i = 0; i < BS; i++) b[i*DW +: DW] = $urandom;
    return b;
  endfunction

  // Backing memory: checks the held request every cycle, acks after ack_delay.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req && !rst) begin
        if (mq.size() == 0) begin
          chk("mem_req_unexpected", 1, 0);
        end else begin
          chk("mem_addr", mem_addr, mq[0].addr);
          chk("mem_we", mem_we, mq[0].we);
          if (mq[0].we) chk("mem_wdata", mem_wdata, mq[0].wdata);
          if (cnt >= ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = mq[0].we ? $urandom : mq[0].rdata;
            void'(mq.pop_front());
            cnt = 0;
          end else begin
            cnt++;
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Scoreboard monitor: every ram_ready pulse must match a queued expectation.
  always @(negedge clk) begin
    if (!rst && ram_ready) begin
      t_ready <= $time;
      if (rq.size() == 0) chk("ready_unexpected", 1, 0);
      else chk("block_at_ready", block_from_ram, rq.pop_front());
    end
  end

  // mode 0: normal, 1: drop ram_en_in during MEM, 2: move ram_addr_in during MEM
  task automatic issue(input logic [AW-1:0] addr, input logic we, input logic [BW-1:0] wb,
                       input int mode, input int delay);
    mreq_t       m;
    logic [OW-1:0] lane;
    int          cyc;
    lane    = addr[OW-1:0];
    m.addr  = addr;
    m.we    = we;
    m.wdata = wb[lane*DW +: DW];
    m.rdata = we ? '0 : mem_rd(addr);
    if (we) mem_model[addr] = m.wdata;
    else    ref_block[lane] = m.rdata;
    @(negedge clk);
    ram_en_in = 1'b1; ram_write_in = we; ram_addr_in = addr; dc_data_wb = wb;
    ack_delay = delay;
    mq.push_back(m);
    if (mode != 1) rq.push_back(ref_pack());
    @(posedge clk);
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc == 1 && mode == 1) ram_en_in = 1'b0;
      if (cyc == 1 && mode == 2) ram_addr_in = addr ^ 30'h0000_0089;
      if (mode != 1 && ram_ready) break;
      if (mode == 1 && !busy) break;
      if (cyc > 60) begin chk("timeout", 1, 0); break; end
    end
    if (mode != 1) chk("latency", cyc, delay + 2);
    @(posedge clk);
    #1 ram_en_in = 1'b0;
    chk("ready_single_pulse", ram_ready, 0);
  endtask

  initial begin
    logic [BW-1:0] wb;
    logic [BW-1:0] exp_blk;
    time           t_prev;
    for (int i = 0; i < BS; i++) ref_block[i] = '0;
    #12;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ram_ready, 0);
    chk("rst_block", block_from_ram, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    @(negedge clk); rst = 1'b0;

    // Single load into lane 3, ack on the second MEM cycle.
    mem_model[30'h103] = 32'hDEADBEEF;
    issue(30'h103, 1'b0, rand_block(), 0, 1);
    exp_blk = '0; exp_blk[3*DW +: DW] = 32'hDEADBEEF;
    chk("lane3_only", block_from_ram, exp_blk);

    // Eight-word burst with same-cycle ack: 3-cycle ready spacing.
    for (int i = 0; i < BS; i++) mem_model[30'h40 + i] = 32'h1000 + i;
    for (int i = 0; i < BS; i++) begin
      t_prev = t_ready;
      issue(30'h40 + i, 1'b0, rand_block(), 0, 0);
      if (i > 0) chk("burst_spacing", t_ready - t_prev, 30);
    end
    for (int i = 0; i < BS; i++) exp_blk[i*DW +: DW] = 32'h1000 + i;
    chk("burst_block", block_from_ram, exp_blk);

    // Write-back of lane 5 leaves the load block alone.
    wb = rand_block(); wb[5*DW +: DW] = 32'hCAFEF00D;
    issue(30'h55, 1'b1, wb, 0, 2);
    chk("wb_block_unchanged", block_from_ram, exp_blk);
    chk("wb_wdata_latched", mem_wdata, 32'hCAFEF00D);

    // Dropped load: memory still completes and the lane is updated, no ready.
    issue(30'h2A, 1'b0, rand_block(), 1, 4);
    chk("drop_lane_updated", block_from_ram, ref_pack());

    // Address moves during MEM: latched 0x10 is used, data in lane 0.
    mem_model[30'h10] = 32'h0BAD_F00D;
    issue(30'h10, 1'b0, rand_block(), 2, 3);
    chk("addr_hold_lane0", block_from_ram[DW-1:0], 32'h0BAD_F00D);

    // Asynchronous reset in the middle of a memory access.
    @(negedge clk);
    ram_en_in = 1'b1; ram_write_in = 1'b0; ram_addr_in = 30'h77; ack_delay = 20;
    mq.push_back('{addr: 30'h77, we: 1'b0, wdata: '0, rdata: mem_rd(30'h77)});
    @(posedge clk); @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_mem_req", mem_req, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", ram_ready, 0);
    chk("arst_block", block_from_ram, 0);
    mq.delete(); rq.delete();
    for (int i = 0; i < BS; i++) ref_block[i] = '0;
    ram_en_in = 1'b0;
    @(negedge clk); rst = 1'b0;
    issue(30'h0E, 1'b0, rand_block(), 0, 1);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(0, 5);
      issue(AW'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), rand_block(),
            (r == 0) ? 1 : ((r == 1) ? 2 : 0), $urandom_range(0, 4));
    end
    chk("final_block", block_from_ram, ref_pack());
    repeat (3) @(negedge clk);
    chk("mem_queue_drained", mq.size(), 0);
    chk("ready_queue_drained", rq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end
endmodule
